// File: rtl/truck_hit_detect.sv
// Player/truck collision detector: accumulates touched player quadrants over a frame,
// reports them with a one-cycle pulse at the next frame start, then ignores hits for a holdoff period.
module truck_hit_detect #(
    parameter int PLAYER_WIDTH   = 32,
    parameter int PLAYER_HEIGHT  = 64,
    parameter int HOLDOFF_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        drawing_request_player,
    input  logic        drawing_request_truck,
    input  logic [10:0] player_offsetX,
    input  logic [10:0] player_offsetY,
    input  logic        penalty_mode,
    input  logic        restart_enable,
    output logic        player_truck_hitPulse,
    output logic [3:0]  HitEdgeCode,
    output logic [7:0]  hit_count
);

    localparam int CNT_W = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [10:0]      HALF_W       = 11'(PLAYER_WIDTH / 2);
    localparam logic [10:0]      HALF_H       = 11'(PLAYER_HEIGHT / 2);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        REPORT,
        HOLDOFF
    } state_t;

    state_t           state;
    logic [3:0]       acc;
    logic [CNT_W-1:0] holdoff_cnt;
    logic             collision;
    logic             is_top;
    logic             is_left;
    logic [3:0]       quad_bit;

    // Quadrant bit of the current pixel; zero when this pixel is not a counted collision.
    always_comb begin
        collision = drawing_request_player & drawing_request_truck & ~penalty_mode;
        is_top    = (player_offsetY < HALF_H);
        is_left   = (player_offsetX < HALF_W);
        quad_bit  = 4'b0000;
        if (collision) begin
            case ({is_top, is_left})
                2'b11:   quad_bit = 4'b1000;
                2'b10:   quad_bit = 4'b0100;
                2'b01:   quad_bit = 4'b0010;
                default: quad_bit = 4'b0001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state                 <= IDLE;
            acc                   <= 4'b0000;
            HitEdgeCode           <= 4'b0000;
            hit_count             <= 8'd0;
            holdoff_cnt           <= '0;
            player_truck_hitPulse <= 1'b0;
        end else if (restart_enable) begin
            state                 <= IDLE;
            acc                   <= 4'b0000;
            HitEdgeCode           <= 4'b0000;
            hit_count             <= 8'd0;
            holdoff_cnt           <= '0;
            player_truck_hitPulse <= 1'b0;
        end else begin
            player_truck_hitPulse <= 1'b0;
            // A pixel coincident with startOfFrame belongs to the new frame.
            if (startOfFrame)
                acc <= quad_bit;
            else
                acc <= acc | quad_bit;

            case (state)
                IDLE: begin
                    if (startOfFrame && (acc != 4'b0000)) begin
                        HitEdgeCode           <= acc;
                        player_truck_hitPulse <= 1'b1;
                        state                 <= REPORT;
                    end
                end
                REPORT: begin
                    if (hit_count != 8'hFF)
                        hit_count <= hit_count + 8'd1;
                    holdoff_cnt <= HOLDOFF_LOAD;
                    state       <= (HOLDOFF_FRAMES == 0) ? IDLE : HOLDOFF;
                end
                HOLDOFF: begin
                    if (startOfFrame) begin
                        if (holdoff_cnt <= CNT_ONE) begin
                            holdoff_cnt <= '0;
                            state       <= IDLE;
                        end else begin
                            holdoff_cnt <= holdoff_cnt - CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truck_hit_detect.md
TRUCK_HIT_DETECT -- requirements
Module: truck_hit_detect

Interface
REQ-001 Parameter PLAYER_WIDTH, default 32: player sprite width in pixels.
REQ-002 Parameter PLAYER_HEIGHT, default 64: player sprite height in pixels.
REQ-003 Parameter HOLDOFF_FRAMES, default 30: frames to ignore collisions after a reported hit.
REQ-004 clk  input  1  system clock; the block uses this one clock and no other.
REQ-005 resetN  input  1  synchronous, active-high reset; resetN=1 resets the block on the next clk edge.
REQ-006 startOfFrame  input  1  one-cycle pulse at the start of each frame.
REQ-007 drawing_request_player  input  1  the current pixel is an opaque player-sprite pixel.
REQ-008 drawing_request_truck  input  1  the current pixel is an opaque truck-sprite pixel.
REQ-009 player_offsetX  input  11  X offset of the current pixel inside the player sprite, unsigned.
REQ-010 player_offsetY  input  11  Y offset of the current pixel inside the player sprite, unsigned.
REQ-011 penalty_mode  input  1  the player is in its crash penalty; collisions are ignored.
REQ-012 restart_enable  input  1  game restart request.
REQ-013 player_truck_hitPulse  output  1  one-cycle pulse that reports a hit detected in the previous frame.
REQ-014 HitEdgeCode  output  4  player quadrants touched: [3]=top-left, [2]=top-right, [1]=bottom-left, [0]=bottom-right.
REQ-015 hit_count  output  8  number of reported hits since reset or restart; saturates at 255.

Function
REQ-016 A collision pixel is any cycle with drawing_request_player=1, drawing_request_truck=1 and penalty_mode=0.
REQ-017 Quadrant of a collision pixel: top when player_offsetY < PLAYER_HEIGHT/2, else bottom; left when player_offsetX < PLAYER_WIDTH/2, else right.
REQ-018 A 4-bit frame accumulator ORs in the quadrant bit of every collision pixel in the current frame.
REQ-019 The state machine has three states: IDLE, REPORT and HOLDOFF.
REQ-020 IDLE: on a cycle with startOfFrame=1 and a nonzero accumulator, load HitEdgeCode with the accumulator and go to REPORT; otherwise stay in IDLE.
REQ-021 REPORT lasts exactly one cycle: player_truck_hitPulse=1, hit_count increments (saturating at 255), the holdoff counter loads HOLDOFF_FRAMES, and the next state is HOLDOFF.
REQ-022 The pulse therefore appears one cycle after the startOfFrame edge; hitPulse is 1 only in REPORT.
REQ-023 HOLDOFF: each startOfFrame decrements the counter; a startOfFrame seen while the counter is 1 returns the block to IDLE.
REQ-024 No report is made from HOLDOFF; with HOLDOFF_FRAMES=0 the block goes straight from REPORT to IDLE.
REQ-025 The accumulator clears on every startOfFrame, in every state.
REQ-026 A collision pixel in the same cycle as startOfFrame is stored as the first pixel of the new frame, not the old one.
REQ-027 HitEdgeCode holds its value until the next REPORT load; the first pixel of a frame does not affect the current report.
REQ-028 penalty_mode=1 only stops accumulation; a frame already accumulated is still reported.
REQ-029 restart_enable=1 for one cycle clears the accumulator, HitEdgeCode and hit_count, and forces IDLE with no pulse.
REQ-030 restart_enable has priority over every other event in the same cycle.
REQ-031 The holdoff counter is ceil(log2(HOLDOFF_FRAMES+1)) bits wide, minimum 1 bit.
REQ-032 Offset comparisons are unsigned, 11 bits wide.

Reset
REQ-033 With resetN=1 at a clk edge, all of the following apply at that edge, and reset overrides restart_enable and all other inputs:
- state = IDLE
- accumulator = 0, HitEdgeCode = 4'b0000
- hit_count = 0, holdoff counter = 0
- player_truck_hitPulse = 0
REQ-034 Reset asserted during REPORT or HOLDOFF ends the operation immediately: no pulse is issued and no count is kept.

Verification
REQ-035 Report timing:
- stimulus: collision pixels at offset (5,10) and offset (20,40) in frame N, then startOfFrame at cycle T
- response: hitPulse=1 only at T+1; HitEdgeCode=4'b1001; hit_count=1
REQ-036 Holdoff, with HOLDOFF_FRAMES=2:
- stimulus: a hit in frame N, then collisions in frames N+1 and N+2
- response: no pulse is reported for those frames; a collision in frame N+3 gives a pulse after the following startOfFrame
REQ-037 Pixel coincident with startOfFrame:
- stimulus: a collision pixel at offset (30,50) in the same cycle as startOfFrame, with the accumulator empty
- response: no pulse at this edge; pulse at the next frame with HitEdgeCode=4'b0001
REQ-038 Penalty mode:
- stimulus: penalty_mode=1 during a whole frame of overlapping pixels
- response: no pulse; HitEdgeCode keeps its old value
REQ-039 Saturation and restart:
- stimulus: 260 spaced hits with HOLDOFF_FRAMES=0, then restart_enable=1 in the same cycle as a startOfFrame with a pending hit
- response: hit_count stops at 255; then no pulse, and hit_count=0 and HitEdgeCode=0
REQ-040 Reset during REPORT:
- stimulus: resetN=1 in the REPORT cycle
- response: at the next edge hitPulse=0, state=IDLE, and all registers at their reset values
